// File: rtl/clock_pkg.sv
// clock_pkg
//   Constants shared by the century-clock counters (date counter and year counter).
//   Mode codes select which field the up/down buttons step; every other code is a run mode.
package clock_pkg;

    localparam logic [2:0] MODE_SET_DAY   = 3'b011;
    localparam logic [2:0] MODE_SET_MONTH = 3'b100;
    localparam logic [2:0] MODE_SET_YEAR  = 3'b101;
    localparam logic [2:0] MODE_SET_WDAY  = 3'b110;

    localparam logic [3:0] MONTH_FEB = 4'd2;
    localparam logic [3:0] MONTH_DEC = 4'd12;

endpackage

// File: rtl/date_counter_month_length.sv
// month_length
//   Combinational days-in-month lookup with Gregorian leap-year rule.
// Ports
//   mont  in  4   month 1..12 (callers sanitise illegal values first)
//   year  in  13  full year
//   dim   out 5   days in that month (28..31)
//   leap  out 1   year is a leap year
module month_length
    import clock_pkg::*;
(
    input  logic [3:0]  mont,
    input  logic [12:0] year,
    output logic [4:0]  dim,
    output logic        leap
);

    always_comb begin
        leap = (year[1:0] == 2'b00) &&
               (((year % 13'd100) != 13'd0) || ((year % 13'd400) == 13'd0));
        case (mont)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            MONTH_FEB:               dim = leap ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/date_counter.sv
// date_counter
//   Day/month/weekday calendar of the century clock. Advances at midnight in the
//   run modes, steps one field per clock edge while a button is held in that
//   field's set mode, and pulses year_carry for one cycle on Dec-31 -> Jan-1.
// Ports
//   clk_1Hz     in   1   1 Hz clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   sec/min/hour in  6/6/5 current time of day
//   year        in   13  current year (month-length decisions)
//   btn_up      in   1   active-low step-up button
//   btn_down    in   1   active-low step-down button
//   mode        in   3   field select (see clock_pkg)
//   day         out  5   day of month 1..31
//   mont        out  4   month 1..12
//   weekday     out  3   0=Sun..6=Sat
//   year_carry  out  1   one-cycle pulse on the New Year rollover
module date_counter
    import clock_pkg::*;
#(
    parameter logic [4:0] RST_DAY  = 5'd1,
    parameter logic [3:0] RST_MONT = 4'd1,
    parameter logic [2:0] RST_WDAY = 3'd1
)(
    input  logic        clk_1Hz,
    input  logic        rst_n,
    input  logic [5:0]  sec,
    input  logic [5:0]  min,
    input  logic [4:0]  hour,
    input  logic [12:0] year,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [2:0]  mode,
    output logic [4:0]  day,
    output logic [3:0]  mont,
    output logic [2:0]  weekday,
    output logic        year_carry
);

    logic       eod;
    logic       up, down;
    logic [3:0] mont_eff, mont_cand;
    logic [4:0] day_eff;
    logic [4:0] dim_cur, dim_cand;
    logic       leap_cur, leap_cand;
    logic       unused_leap;

    logic [4:0] day_n;
    logic [3:0] mont_n;
    logic [2:0] wday_n;
    logic       carry_n;

    assign eod  = (sec == 6'd59) && (min == 6'd59) && (hour == 5'd23);
    assign up   = ~btn_up;
    assign down = ~btn_down;

    // Forced illegal values behave as the first day / first month.
    assign mont_eff = ((mont == 4'd0) || (mont > MONTH_DEC)) ? 4'd1 : mont;
    assign day_eff  = (day == 5'd0) ? 5'd1 : day;

    // Month that the set-month buttons would move to on this edge.
    always_comb begin
        mont_cand = mont_eff;
        if (up)
            mont_cand = (mont_eff == MONTH_DEC) ? 4'd1 : mont_eff + 4'd1;
        else if (down)
            mont_cand = (mont_eff == 4'd1) ? MONTH_DEC : mont_eff - 4'd1;
    end

    month_length u_len_cur (
        .mont (mont_eff),
        .year (year),
        .dim  (dim_cur),
        .leap (leap_cur)
    );

    month_length u_len_cand (
        .mont (mont_cand),
        .year (year),
        .dim  (dim_cand),
        .leap (leap_cand)
    );

    assign unused_leap = leap_cur ^ leap_cand;

    always_comb begin
        day_n   = day;
        mont_n  = mont;
        wday_n  = weekday;
        carry_n = 1'b0;
        case (mode)
            MODE_SET_DAY: begin
                if (up)
                    day_n = (day_eff >= dim_cur) ? 5'd1 : day_eff + 5'd1;
                else if (down)
                    day_n = (day_eff == 5'd1) ? dim_cur : day_eff - 5'd1;
            end
            MODE_SET_MONTH: begin
                if (up || down) begin
                    mont_n = mont_cand;
                    day_n  = (dim_cand < day_eff) ? dim_cand : day_eff;
                end
            end
            MODE_SET_WDAY: begin
                if (up)
                    wday_n = (weekday >= 3'd6) ? 3'd0 : weekday + 3'd1;
                else if (down)
                    wday_n = (weekday == 3'd0) ? 3'd6 : weekday - 3'd1;
            end
            default: begin
                // Run modes, including set-year: the calendar keeps going.
                if (eod) begin
                    wday_n = (weekday >= 3'd6) ? 3'd0 : weekday + 3'd1;
                    if (day_eff < dim_cur) begin
                        day_n = day_eff + 5'd1;
                    end else if (day_eff == dim_cur) begin
                        day_n = 5'd1;
                        if (mont_eff == MONTH_DEC) begin
                            mont_n  = 4'd1;
                            carry_n = 1'b1;
                        end else begin
                            mont_n = mont_eff + 4'd1;
                        end
                    end
                end
            end
        endcase
        // A day beyond the current month's length (e.g. year changed under
        // Feb-29) is pulled back, overriding whatever else happened to day.
        if (day_eff > dim_cur)
            day_n = dim_cur;
    end

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            day        <= RST_DAY;
            mont       <= RST_MONT;
            weekday    <= RST_WDAY;
            year_carry <= 1'b0;
        end else begin
            day        <= day_n;
            mont       <= mont_n;
            weekday    <= wday_n;
            year_carry <= carry_n;
        end
    end

endmodule

// File: tb/tb_date_counter.sv
// tb_date_counter
//   Directed calendar scenarios followed by randomized stimulus, compared
//   against a day/month/weekday reference model built from calendar rules.
module tb_date_counter;

    logic        clk_1Hz;
    logic        rst_n;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [12:0] year;
    logic        btn_up;
    logic        btn_down;
    logic [2:0]  mode;
    logic [4:0]  day;
    logic [3:0]  mont;
    logic [2:0]  weekday;
    logic        year_carry;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Reference model state.
    int m_day, m_mont, m_wday, m_carry;

    // Scoreboard: packed {day, mont, weekday, carry} expected after each edge.
    logic [12:0] exp_q[$];

    date_counter dut (
        .clk_1Hz    (clk_1Hz),
        .rst_n      (rst_n),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .year       (year),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .mode       (mode),
        .day        (day),
        .mont       (mont),
        .weekday    (weekday),
        .year_carry (year_carry)
    );

    // ---------------- clock ----------------
    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    // ---------------- model ----------------
    function automatic bit is_leap(int y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic int dim_of(int m, int y);
        case (m)
            2:            return is_leap(y) ? 29 : 28;
            4, 6, 9, 11:  return 30;
            default:      return 31;
        endcase
    endfunction

    task automatic model_reset();
        m_day = 1; m_mont = 1; m_wday = 1; m_carry = 0;
    endtask

    task automatic model_step();
        int dim, nd, nm, nw, nc, ndim;
        bit is_eod, up, dn;
        dim = dim_of(m_mont, int'(year));
        nd = m_day; nm = m_mont; nw = m_wday; nc = 0;
        is_eod = (sec == 59) && (min == 59) && (hour == 23);
        up = !btn_up;
        dn = !btn_down;
        if (mode == 3'b011) begin
            if (up)      nd = (m_day == dim) ? 1 : m_day + 1;
            else if (dn) nd = (m_day == 1) ? dim : m_day - 1;
        end else if (mode == 3'b100) begin
            if (up || dn) begin
                nm = up ? (m_mont % 12) + 1 : ((m_mont + 10) % 12) + 1;
                ndim = dim_of(nm, int'(year));
                nd = (m_day > ndim) ? ndim : m_day;
            end
        end else if (mode == 3'b110) begin
            if (up)      nw = (m_wday + 1) % 7;
            else if (dn) nw = (m_wday + 6) % 7;
        end else if (is_eod) begin
            nw = (m_wday + 1) % 7;
            if (m_day < dim) nd = m_day + 1;
            else if (m_day == dim) begin
                nd = 1;
                if (m_mont == 12) begin nm = 1; nc = 1; end
                else nm = m_mont + 1;
            end
        end
        if (m_day > dim) nd = dim;
        m_day = nd; m_mont = nm; m_wday = nw; m_carry = nc;
    endtask

    // ---------------- checking ----------------
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Inputs change on the falling edge; outputs are checked one falling edge later.
    task automatic step();
        logic [12:0] e;
        model_step();
        exp_q.push_back({m_day[4:0], m_mont[3:0], m_wday[2:0], m_carry[0]});
        @(posedge clk_1Hz);
        @(negedge clk_1Hz);
        e = exp_q.pop_front();
        check("day",        32'(day),        32'(e[12:8]));
        check("mont",       32'(mont),       32'(e[7:4]));
        check("weekday",    32'(weekday),    32'(e[3:1]));
        check("year_carry", 32'(year_carry), 32'(e[0]));
    endtask

    task automatic set_time(int h, int m, int s);
        hour = 5'(h); min = 6'(m); sec = 6'(s);
    endtask

    task automatic press_up(logic [2:0] md);
        mode = md; btn_up = 1'b0; btn_down = 1'b1;
        step();
        btn_up = 1'b1;
    endtask

    // Walk the fields to the requested date through the set modes.
    task automatic set_date(int d, int m, int w);
        set_time(12, 0, 0);
        for (int i = 0; i < 12 && m_mont != m; i++) press_up(3'b100);
        for (int i = 0; i < 31 && m_day != d; i++) press_up(3'b011);
        for (int i = 0; i < 7 && m_wday != w; i++) press_up(3'b110);
        mode = 3'b000;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; btn_up = 1'b1; btn_down = 1'b1; mode = 3'b000;
        year = 13'd2001; set_time(0, 0, 0);
        model_reset();
        #12;
        check("rst_day",   32'(day), 1);
        check("rst_mont",  32'(mont), 1);
        check("rst_wday",  32'(weekday), 1);
        check("rst_carry", 32'(year_carry), 0);
        @(negedge clk_1Hz);
        rst_n = 1'b1;

        // Month end: 30-Apr -> 1-May.
        set_date(30, 4, 3);
        set_time(23, 59, 59);
        step();
        check("apr_end_day", 32'(day), 1);
        check("apr_end_mont", 32'(mont), 5);

        // Year end: 31-Dec-2001 -> 1-Jan with a single-cycle carry.
        set_date(31, 12, 1);
        set_time(23, 59, 59);
        step();
        check("ny_carry", 32'(year_carry), 1);
        check("ny_wday", 32'(weekday), 2);
        set_time(0, 0, 0);
        step();
        check("ny_carry_drop", 32'(year_carry), 0);

        // Leap rules at 28-Feb midnight.
        year = 13'd2024; set_date(28, 2, 0); set_time(23, 59, 59); step();
        check("leap2024", 32'(day), 29);
        year = 13'd2100; set_date(28, 2, 0); set_time(23, 59, 59); step();
        check("leap2100_mont", 32'(mont), 3);
        year = 13'd2000; set_date(28, 2, 0); set_time(23, 59, 59); step();
        check("leap2000_d29", 32'(day), 29);
        step();
        check("leap2000_mar", 32'(mont), 3);

        // Set day in Feb 2023 with eod present and ignored.
        year = 13'd2023; set_date(28, 2, 0); set_time(23, 59, 59);
        mode = 3'b011; btn_up = 1'b0; btn_down = 1'b1;
        step(); check("setday_wrap", 32'(day), 1);
        step(); check("setday_two", 32'(day), 2);
        btn_up = 1'b1; btn_down = 1'b0;
        step(); step(); check("setday_down_wrap", 32'(day), 28);
        btn_up = 1'b0;
        step(); check("setday_both_up", 32'(day), 1);
        btn_up = 1'b1; btn_down = 1'b1;

        // Set month with day reduction.
        year = 13'd2023; set_date(31, 3, 0);
        mode = 3'b100; btn_up = 1'b0; step(); btn_up = 1'b1;
        check("setmon_apr30", 32'(day), 30);
        set_date(1, 1, 0); set_date(31, 1, 0);
        mode = 3'b100; btn_down = 1'b0; step(); btn_down = 1'b1;
        check("setmon_dec", 32'(mont), 12);
        check("setmon_dec31", 32'(day), 31);

        // Clamp after year change, weekday wrap.
        year = 13'd2024; set_date(29, 2, 6);
        year = 13'd2023; mode = 3'b000; set_time(10, 0, 0); step();
        check("clamp_feb", 32'(day), 28);
        mode = 3'b110; btn_up = 1'b0; step(); btn_up = 1'b1;
        check("wday_wrap", 32'(weekday), 0);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_day",   32'(day), 1);
        check("mid_rst_mont",  32'(mont), 1);
        check("mid_rst_wday",  32'(weekday), 1);
        check("mid_rst_carry", 32'(year_carry), 0);
        model_reset();
        @(negedge clk_1Hz);
        rst_n = 1'b1;

        // Randomized run mixing modes, buttons, midnight and year changes.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    mode = 3'b011;
                2:       mode = 3'b100;
                3:       mode = 3'b110;
                4:       mode = 3'b101;
                default: mode = 3'($urandom_range(0, 2));
            endcase
            btn_up   = ($urandom_range(0, 2) != 0);
            btn_down = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1) set_time(23, 59, 59);
            else set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0: year = 13'd2000;
                    1: year = 13'd2024;
                    2: year = 13'd2100;
                    3: year = 13'd2023;
                    default: year = 13'($urandom_range(2001, 2199));
                endcase
            end
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
